mem_initiator: RTL

//  Request-side master for the 64 x 16 instruction/data memory. Accepts one

---
 rtl/mem_initiator.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - single-request load/store master for the 64x16 memory
// Bursts of 1..2**LENW read beats at incrementing (wrapping) addresses; all progress gated by StepIn.
module mem_initiator #(
  parameter int AW   = 6,
  parameter int DW   = 16,
  parameter int LENW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StepIn,
  input  logic            Req,
  input  logic            RdWr,
  input  logic [AW-1:0]   ReqAdrs,
  input  logic [DW-1:0]   ReqData,
  input  logic [LENW-1:0] BurstLen,
  input  logic [DW-1:0]   MemDout,
  output logic [AW-1:0]   MemAdrs,
  output logic [DW-1:0]   MemDin,
  output logic            MemWrt,
  output logic            MemStep,
  output logic [DW-1:0]   RdData,
  output logic            RdValid,
  output logic            Busy,
  output logic            Done
);

  typedef enum logic [1:0] {IDLE, ADDR, XFER, DONE} state_t;

  state_t          state_q, state_d;
  logic            op_q;
  logic [LENW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    MemWrt  = 1'b0;
    MemStep = 1'b0;
    Done    = 1'b0;
    Busy    = 1'b1;
    case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (Req && StepIn) state_d = ADDR;
      end
      ADDR: begin
        if (StepIn) state_d = XFER;
      end
      XFER: begin
        MemWrt  = op_q;
        MemStep = StepIn;
        // Writes are always single-beat, so count is 0 for them too
        if (StepIn) state_d = (op_q || count_q == '0) ? DONE : ADDR;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemAdrs <= '0;
      MemDin  <= '0;
      RdData  <= '0;
      RdValid <= 1'b0;
      op_q    <= 1'b0;
      count_q <= '0;
    end else begin
      RdValid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Req && StepIn) begin
            MemAdrs <= ReqAdrs;
            MemDin  <= ReqData;
            op_q    <= RdWr;
            count_q <= RdWr ? '0 : BurstLen;
          end
        end
        XFER: begin
          if (StepIn && !op_q) begin
            RdData  <= MemDout;
            RdValid <= 1'b1;
            if (count_q != '0) begin
              count_q <= count_q - LENW'(1);
              MemAdrs <= MemAdrs + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
